fsm_stream_sequencer: RTL and testbench
=======================================

# fsm_stream_sequencer

Run controller for the four-in-a-row sequence detector (the `w`/`z` FSM with active-low asynchronous clear). It latches a pattern word, clears the detector, and feeds the pattern to it serially, LSB first, one bit per clock. It samples the detector's Moore output `z` after each bit and reports how many bits ended in a detected state, plus the bit index of the first detection. It sits between a board-level loader (switches/keys or a test master) and one detector instance, and it owns that instance's `w` and `aclr` pins.

## Interface
- WIDTH, 16: pattern length in bits (max bits per run).
- LEN_W, 5: width of `len`; must satisfy 2^LEN_W > WIDTH.
- CNT_W, 5: width of `match_count` and `first_idx`; must hold WIDTH.

Ports:
- clk  in  1  rising-edge clock, shared with the detector.
- clr  in  1  synchronous, active-high reset.
- start  in  1  run request, sampled only in IDLE.
- pattern  in  WIDTH  bit stream, bit 0 sent first; latched on accepted start.
- len  in  LEN_W  number of bits to send; latched on accepted start; values >WIDTH saturate to WIDTH.
- det_w  out  1  drives detector `w`.
- det_aclr  out  1  drives detector active-low clear.
- det_z  in  1  detector `z` output.
- busy  out  1  high in CLEAR, SHIFT, FLUSH.
- done  out  1  one-cycle pulse; results valid.
- hit  out  1  at least one detection in last run.
- match_count  out  CNT_W  number of sampled `det_z`=1 cycles in last run.
- first_idx  out  CNT_W  bit index whose acceptance first produced `det_z`=1; 0 when !hit.

## Operation
- States: IDLE, CLEAR, SHIFT, FLUSH, DONE. Encoding is free.
- IDLE: on start=1, latch pattern and len_eff = min(len, WIDTH), then go to CLEAR. Otherwise stay in IDLE.
- CLEAR: det_aclr=0 for exactly this cycle. Zero hit, match_count, first_idx, and bit index k.
  - Next state is SHIFT if len_eff>0, else DONE.
- SHIFT: det_w = pattern_q[k]; k increments each cycle.
  - For k≥1, sample det_z as the result of bit k-1.
  - After bit len_eff-1 is sent, go to FLUSH.
- FLUSH: det_w=0 (don't-care to the result). Sample det_z as the result of bit len_eff-1. Go to DONE.
- DONE: done=1 for one cycle. Go to IDLE.
- Sampling rule: on each sample with det_z=1, match_count += 1. If hit was 0, set hit=1 and first_idx=bit index.
  - match_count never exceeds len_eff, so it cannot overflow.
- det_z is ignored in IDLE, CLEAR, the first SHIFT cycle (k=0), and DONE.
- det_w=0 and det_aclr=1 in every state except as stated above.
- det_w and det_aclr are decoded from registered state only, so they carry no combinational path from inputs.
- hit, match_count and first_idx hold their values from DONE until the next CLEAR.
- start while busy or in DONE is ignored; it is not queued.

## Timing
- Reset (clr=1 at an edge): state=IDLE, busy=0, done=0, hit=0, match_count=0, first_idx=0, det_w=0, det_aclr=1, k=0.
- clr takes priority over every transition. clr mid-run aborts to IDLE with results zeroed and no done pulse. The detector is not cleared until the next CLEAR.
- Start accepted at cycle 0 (IDLE):
  - Cycle 1: CLEAR.
  - Cycles 2..len_eff+1: SHIFT.
  - Cycle len_eff+2: FLUSH.
  - Cycle len_eff+3: DONE (done=1).
  - Earliest next start: the cycle after DONE.
- len_eff=0: CLEAR at cycle 1, DONE at cycle 2, all results 0.
- Detector latency assumption: `z` reflects the bit presented in cycle t during cycle t+1. This is the reason for the one-cycle sampling offset and FLUSH.

## Test plan
- pattern=16'h000F, len=16, start -> done at cycle 19, match_count=10, hit=1, first_idx=3; det_aclr low only in cycle 1.
- pattern=16'hAAAA, len=16 -> match_count=0, hit=0, first_idx=0; done at cycle 19.
- pattern=16'h00FF, len=8 -> match_count=5, first_idx=3, done at cycle 11; det_w sequence 1,1,1,1,1,1,1,1 then 0 in FLUSH.
- len=0, start -> done at cycle 2, all results 0, no SHIFT cycles.
- len=20, pattern=16'hFFFF -> saturates to 16; match_count=13, first_idx=3, done at cycle 19.
- clr asserted in the 5th SHIFT cycle, with start pulses during busy -> IDLE next cycle, results 0, no done. Starts during busy are ignored. A fresh run afterwards reproduces the first scenario exactly.

Source files
------------

// File: rtl/fsm_stream_sequencer_if.sv
// Loader/detector-side signal bundle for the stream sequencer.
// The slave modport is the sequencer; the master modport is the loader plus detector.
interface fsm_stream_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5,
  parameter int CNT_W = 5
) ();
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic             det_w;
  logic             det_aclr;
  logic             det_z;
  logic             busy;
  logic             done;
  logic             hit;
  logic [CNT_W-1:0] match_count;
  logic [CNT_W-1:0] first_idx;

  modport slave (
    input  start, pattern, len, det_z,
    output det_w, det_aclr, busy, done, hit, match_count, first_idx
  );

  modport master (
    output start, pattern, len, det_z,
    input  det_w, det_aclr, busy, done, hit, match_count, first_idx
  );
endinterface

// File: rtl/fsm_stream_sequencer.sv
// Run controller for a four-in-a-row detector: clears it, shifts a pattern in LSB first,
// and counts detections using a one-cycle z sampling offset plus a trailing FLUSH cycle.
module fsm_stream_sequencer #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5,
  parameter int CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  clr,
  fsm_stream_sequencer_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SHIFT, S_FLUSH, S_DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] k_q;
  logic             hit_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] first_q;
  logic             det_w_q;
  logic             det_aclr_q;
  logic             busy_q;
  logic             done_q;

  logic             samp;
  logic [WIDTH-1:0] pat_nxt;

  // z during this cycle reflects the bit sent last cycle, i.e. bit k-1.
  assign samp    = bus.det_z && ((state_q == S_SHIFT && k_q != '0) || state_q == S_FLUSH);
  assign pat_nxt = pat_q >> 1;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      pat_q      <= '0;
      len_q      <= '0;
      k_q        <= '0;
      hit_q      <= 1'b0;
      cnt_q      <= '0;
      first_q    <= '0;
      det_w_q    <= 1'b0;
      det_aclr_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      det_w_q    <= 1'b0;
      det_aclr_q <= 1'b1;
      if (samp) begin
        cnt_q <= cnt_q + 1'b1;
        if (!hit_q) begin
          hit_q   <= 1'b1;
          first_q <= CNT_W'(k_q - 1'b1);
        end
      end
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            pat_q      <= bus.pattern;
            len_q      <= (bus.len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : bus.len;
            state_q    <= S_CLEAR;
            busy_q     <= 1'b1;
            det_aclr_q <= 1'b0;
          end
        end
        S_CLEAR: begin
          hit_q   <= 1'b0;
          cnt_q   <= '0;
          first_q <= '0;
          k_q     <= '0;
          if (len_q != '0) begin
            state_q <= S_SHIFT;
            det_w_q <= pat_q[0];
          end else begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_SHIFT: begin
          k_q   <= k_q + 1'b1;
          pat_q <= pat_nxt;
          if (k_q == len_q - 1'b1) state_q <= S_FLUSH;
          else                     det_w_q <= pat_nxt[0];
        end
        S_FLUSH: begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.det_w       = det_w_q;
  assign bus.det_aclr    = det_aclr_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hit         = hit_q;
  assign bus.match_count = cnt_q;
  assign bus.first_idx   = first_q;

endmodule

// File: tb/tb_fsm_stream_sequencer.sv
// Directed plus random runs of the sequencer driving a behavioural four-in-a-row detector.
module tb_fsm_stream_sequencer;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  fsm_stream_sequencer_if #(.WIDTH(16), .LEN_W(5), .CNT_W(5)) ifc ();

  fsm_stream_sequencer #(.WIDTH(16), .LEN_W(5), .CNT_W(5)) dut (
    .clk (clk),
    .clr (clr),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  // Detector: Moore output, z=1 once the last four accepted bits were all equal.
  int   run_len = 0;
  logic last_w  = 1'b0;
  always @(posedge clk or negedge ifc.det_aclr) begin
    if (!ifc.det_aclr) begin
      run_len <= 0;
      last_w  <= 1'b0;
    end else if (run_len == 0 || ifc.det_w != last_w) begin
      run_len <= 1;
      last_w  <= ifc.det_w;
    end else if (run_len < 4) begin
      run_len <= run_len + 1;
    end
  end
  assign ifc.det_z = (run_len == 4);

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference: a detection at bit i means bits i-3..i of the stream are all equal.
  task automatic model(input logic [15:0] p, input int L,
                       output int hit, output int cnt, output int first);
    logic [3:0] win;
    hit = 0; cnt = 0; first = 0;
    for (int i = 3; i < L; i++) begin
      win = p[i-3 +: 4];
      if (win == 4'hF || win == 4'h0) begin
        if (hit == 0) first = i;
        hit = 1;
        cnt++;
      end
    end
  endtask

  task automatic run(input string nm, input logic [15:0] p, input int ln, input bit noisy);
    int L, dexp, ehit, ecnt, efirst;
    int done_c, aclr_low, aclr_c, busy_bad, flush_w;
    int wbits, mask;
    L    = (ln > 16) ? 16 : ln;
    dexp = (L == 0) ? 2 : L + 3;
    model(p, L, ehit, ecnt, efirst);
    mask = (1 << L) - 1;
    done_c = -1; aclr_low = 0; aclr_c = -1; busy_bad = 0; flush_w = 0; wbits = 0;
    ifc.pattern = p;
    ifc.len     = 5'(ln);
    ifc.start   = 1'b1;
    for (int c = 1; c <= 40 && done_c < 0; c++) begin
      tick();
      ifc.start = noisy && c >= 2;
      if (!ifc.det_aclr) begin aclr_low++; aclr_c = c; end
      if (c >= 2 && c <= L + 1) wbits |= int'(ifc.det_w) << (c - 2);
      if (L > 0 && c == L + 2) flush_w = int'(ifc.det_w);
      if (ifc.busy !== (c < dexp)) busy_bad++;
      if (ifc.done) done_c = c;
    end
    chk({nm, ".done_cycle"}, done_c, dexp);
    chk({nm, ".aclr_low_cycles"}, aclr_low, 1);
    chk({nm, ".aclr_low_at"}, aclr_c, 1);
    chk({nm, ".w_stream"}, wbits, int'(p) & mask);
    if (L > 0) chk({nm, ".w_flush"}, flush_w, 0);
    chk({nm, ".busy_profile_errs"}, busy_bad, 0);
    chk({nm, ".hit"}, int'(ifc.hit), ehit);
    chk({nm, ".match_count"}, int'(ifc.match_count), ecnt);
    chk({nm, ".first_idx"}, int'(ifc.first_idx), efirst);
    tick();
    ifc.start = 1'b0;
    chk({nm, ".done_one_cycle"}, int'(ifc.done), 0);
    chk({nm, ".hold_count"}, int'(ifc.match_count), ecnt);
    chk({nm, ".hold_first"}, int'(ifc.first_idx), efirst);
    tick();
    chk({nm, ".idle_after"}, int'(ifc.busy), 0);
  endtask

  initial begin
    int ndone;
    ifc.start = 1'b0; ifc.pattern = '0; ifc.len = '0;
    tick(); tick();
    chk("rst.busy", int'(ifc.busy), 0);
    chk("rst.done", int'(ifc.done), 0);
    chk("rst.hit", int'(ifc.hit), 0);
    chk("rst.count", int'(ifc.match_count), 0);
    chk("rst.first", int'(ifc.first_idx), 0);
    chk("rst.w", int'(ifc.det_w), 0);
    chk("rst.aclr", int'(ifc.det_aclr), 1);
    clr = 1'b0;
    tick();

    run("p000F", 16'h000F, 16, 1'b0);
    run("pAAAA", 16'hAAAA, 16, 1'b0);
    run("p00FF", 16'h00FF, 8, 1'b0);
    run("len0", 16'h1234, 0, 1'b0);
    run("sat20", 16'hFFFF, 20, 1'b0);
    run("noisy", 16'h0F0F, 16, 1'b1);

    // Abort in the 5th SHIFT cycle (cycle 6) with start pulses while busy.
    ifc.pattern = 16'h000F; ifc.len = 5'd16; ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      tick();
      ifc.start = (c < 6) && c[0];
    end
    chk("abort.busy_before", int'(ifc.busy), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("abort.busy", int'(ifc.busy), 0);
    chk("abort.done", int'(ifc.done), 0);
    chk("abort.hit", int'(ifc.hit), 0);
    chk("abort.count", int'(ifc.match_count), 0);
    chk("abort.first", int'(ifc.first_idx), 0);
    chk("abort.w", int'(ifc.det_w), 0);
    chk("abort.aclr", int'(ifc.det_aclr), 1);
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (ifc.done || ifc.busy) ndone++;
    end
    chk("abort.no_activity", ndone, 0);
    run("rerun000F", 16'h000F, 16, 1'b0);

    for (int r = 0; r < 12; r++) begin
      run($sformatf("rand%0d", r), 16'($urandom), int'($urandom_range(0, 20)),
          bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
